// File: rtl/stack_unloader_pkg.sv
// Shared stack geometry and unloader FSM encoding.
// No logic of its own; imported by the unloader and anything sharing the Stack's sizing.
// Widths follow the Stack: CNT_W must hold 0..DEPTH inclusive.
package stack_unloader_pkg;

    localparam int STK_DATA_W = 8;
    localparam int STK_DEPTH  = 8;
    localparam int STK_CNT_W  = $clog2(STK_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_CAPT = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } unload_state_t;

endpackage

// File: rtl/stack_unloader.sv
// Pops N entries (or all when count==0) from the LIFO and streams them newest-first.
// Latency: start -> first m_valid in 3 edges; at least 3 cycles per entry (POP, CAPT, OUT).
// Backpressure: OUT holds m_valid/m_data/m_last until m_ready; no further pop until handshake.
module stack_unloader
    import stack_unloader_pkg::*;
#(
    parameter int DATA_W = STK_DATA_W,
    parameter int DEPTH  = STK_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              short,
    output logic              stk_pop,
    input  logic              stk_empty,
    input  logic [DATA_W-1:0] stk_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    unload_state_t     state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              mode_all_q, mode_all_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              m_valid_q, m_valid_d;
    logic              pop_c, done_c, short_c;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            mode_all_q  <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mode_all_q  <= mode_all_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        mode_all_d  = mode_all_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        pop_c       = 1'b0;
        done_c      = 1'b0;
        short_c     = 1'b0;

        if (abort) begin
            // Anything already popped is dropped; the consumer never sees it.
            state_d   = S_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        remaining_d = count;
                        mode_all_d  = (count == '0);
                        state_d     = stk_empty ? S_DONE : S_POP;
                    end
                end
                S_POP: begin
                    if (!stk_empty) begin
                        pop_c   = 1'b1;
                        state_d = S_CAPT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_CAPT: begin
                    // stk_empty here is the post-pop flag, so it marks the entry that drained the stack.
                    m_data_d  = stk_dout;
                    m_last_d  = stk_empty | (!mode_all_q && remaining_q == CNT_W'(1));
                    m_valid_d = 1'b1;
                    if (!mode_all_q) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                    state_d = S_OUT;
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = m_last_q ? S_DONE : S_POP;
                    end
                end
                S_DONE: begin
                    done_c  = 1'b1;
                    short_c = !mode_all_q && (remaining_q != '0);
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by rstn so nothing reaches the Stack during a reset cycle.
    assign stk_pop = pop_c & rstn;
    assign done    = done_c & rstn;
    assign short   = short_c & rstn;
    assign busy    = (state_q != S_IDLE);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule
